// File: rtl/seg_scan_ctrl_if.sv
// Bus bundle for the multiplexed 7-segment scan controller.
// Master drives control/data, slave returns the display drive.
interface seg_scan_ctrl_if;
   logic        en;
   logic        wr;
   logic [15:0] wr_data;
   logic [3:0]  blank_mask;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        pend;
   logic        frame;

   modport master (
      output en, wr, wr_data, blank_mask,
      input  seg, an, pend, frame
   );

   modport slave (
      input  en, wr, wr_data, blank_mask,
      output seg, an, pend, frame
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller with guard blanking,
// shadow register and frame-aligned display update.
module seg_scan_ctrl #(
   parameter int unsigned DIV   = 50000,
   parameter int unsigned GUARD = 4
) (
   input logic           clk,
   input logic           reset,
   seg_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GUARD,
      ST_DRIVE
   } state_t;

   localparam logic [15:0] C_GL = 16'(GUARD - 1);
   localparam logic [15:0] C_DL = 16'(DIV - 1);

   state_t      r_state, w_state_nx;
   logic [15:0] r_cnt, w_cnt_nx;
   logic [1:0]  r_dig, w_dig_nx;
   logic [15:0] r_disp, w_disp_nx;
   logic [15:0] r_shadow, w_shadow_nx;
   logic        r_pend, w_pend_nx;
   logic        r_frame, w_bound;
   logic [6:0]  r_seg, w_seg_nx;
   logic [3:0]  r_an, w_an_nx;
   logic [3:0]  w_nib;

   function automatic logic [6:0] f_dec(input logic [3:0] n);
      logic [6:0] s;
      s = 7'h7F;
      unique case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_dig_nx   = r_dig;
      w_bound    = 1'b0;
      if (!bus.en) begin
         w_state_nx = ST_IDLE;
         w_cnt_nx   = '0;
         w_dig_nx   = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_state_nx = ST_GUARD;
               w_cnt_nx   = '0;
               w_dig_nx   = '0;
               w_bound    = 1'b1;
            end
            ST_GUARD: begin
               w_cnt_nx = r_cnt + 16'd1;
               if (r_cnt == C_GL) w_state_nx = ST_DRIVE;
            end
            ST_DRIVE: begin
               if (r_cnt == C_DL) begin
                  w_cnt_nx   = '0;
                  w_dig_nx   = r_dig + 2'd1;
                  w_state_nx = ST_GUARD;
                  w_bound    = (r_dig == 2'd3);
               end else begin
                  w_cnt_nx = r_cnt + 16'd1;
               end
            end
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   // A write landing on a frame boundary bypasses the shadow.
   always_comb begin
      w_disp_nx   = r_disp;
      w_shadow_nx = r_shadow;
      w_pend_nx   = r_pend;
      if (w_bound) begin
         if (bus.wr) begin
            w_disp_nx   = bus.wr_data;
            w_shadow_nx = bus.wr_data;
            w_pend_nx   = 1'b0;
         end else if (r_pend) begin
            w_disp_nx = r_shadow;
            w_pend_nx = 1'b0;
         end
      end else if (bus.wr) begin
         w_shadow_nx = bus.wr_data;
         w_pend_nx   = 1'b1;
      end
   end

   always_comb begin
      w_nib    = w_disp_nx[3:0];
      w_an_nx  = 4'hF;
      w_seg_nx = 7'h7F;
      unique case (w_dig_nx)
         2'd0: w_nib = w_disp_nx[3:0];
         2'd1: w_nib = w_disp_nx[7:4];
         2'd2: w_nib = w_disp_nx[11:8];
         2'd3: w_nib = w_disp_nx[15:12];
      endcase
      if (w_state_nx == ST_DRIVE && !bus.blank_mask[w_dig_nx]) begin
         w_an_nx  = ~(4'b0001 << w_dig_nx);
         w_seg_nx = f_dec(w_nib);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_dig    <= '0;
         r_disp   <= '0;
         r_shadow <= '0;
         r_pend   <= 1'b0;
         r_frame  <= 1'b0;
         r_an     <= 4'hF;
         r_seg    <= 7'h7F;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_dig    <= w_dig_nx;
         r_disp   <= w_disp_nx;
         r_shadow <= w_shadow_nx;
         r_pend   <= w_pend_nx;
         r_frame  <= w_bound;
         r_an     <= w_an_nx;
         r_seg    <= w_seg_nx;
      end
   end

   assign bus.seg   = r_seg;
   assign bus.an    = r_an;
   assign bus.pend  = r_pend;
   assign bus.frame = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected lit slots are queued
// with the stimulus and matched against each observed lit run.
module tb_seg_scan_ctrl;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic [7:0] len;
   } slot_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   t = 0;
   bit   mon_on = 0;
   bit   mask_on = 0;
   int   multi = 0;
   int   mviol = 0;
   int   darkbad = 0;
   int   segbad = 0;
   bit   run_act = 0;
   logic [3:0] run_an;
   logic [6:0] run_seg;
   int   run_len;
   slot_t q[$];

   seg_scan_ctrl_if sif ();

   seg_scan_ctrl #(.DIV(8), .GUARD(2)) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (sif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] an, input logic [6:0] seg,
                       input logic [7:0] len);
      slot_t e;
      e.an  = an;
      e.seg = seg;
      e.len = len;
      q.push_back(e);
   endtask

   task automatic close_run();
      slot_t e;
      if (q.size() == 0) begin
         chk("sb_under", 1, 0);
      end else begin
         e = q.pop_front();
         chk("slot_an", 32'(run_an), 32'(e.an));
         chk("slot_seg", 32'(run_seg), 32'(e.seg));
         chk("slot_len", 32'(run_len), 32'(e.len));
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if ($countones(~sif.an) > 1) multi++;
         if (mask_on && (!sif.an[0] || !sif.an[2])) mviol++;
         if (sif.an == 4'hF && sif.seg != 7'h7F) darkbad++;
         if (run_act && sif.an != run_an) begin
            close_run();
            run_act = 0;
         end
         if (sif.an != 4'hF) begin
            if (!run_act) begin
               run_act = 1;
               run_an  = sif.an;
               run_seg = sif.seg;
               run_len = 1;
            end else begin
               run_len++;
               if (sif.seg != run_seg) segbad++;
            end
         end
      end
   end

   task automatic goto(input int n);
      while (t < n) begin
         @(posedge clk);
         #1;
         t++;
      end
   endtask

   initial begin
      reset = 1'b1;
      sif.en = 1'b0;
      sif.wr = 1'b0;
      sif.wr_data = '0;
      sif.blank_mask = '0;
      goto(2);
      reset = 1'b0;
      chk("rst_an", 32'(sif.an), 32'hF);
      chk("rst_seg", 32'(sif.seg), 32'h7F);
      chk("rst_pend", 32'(sif.pend), 0);
      chk("rst_frame", 32'(sif.frame), 0);
      mon_on = 1;

      sif.wr = 1'b1;
      sif.wr_data = 16'h1234;
      goto(3);
      sif.wr = 1'b0;
      chk("pend_idle_wr", 32'(sif.pend), 1);
      push(4'b1110, 7'h19, 6);
      push(4'b1101, 7'h30, 6);
      push(4'b1011, 7'h24, 6);
      push(4'b0111, 7'h79, 6);
      sif.en = 1'b1;
      t = -1;
      goto(0);
      chk("f1_frame", 32'(sif.frame), 1);
      chk("f1_pend", 32'(sif.pend), 0);
      chk("f1_an", 32'(sif.an), 32'hF);
      goto(1);
      chk("f1_frame_end", 32'(sif.frame), 0);

      goto(10);
      sif.wr = 1'b1;
      sif.wr_data = 16'hABCD;
      push(4'b1110, 7'h21, 6);
      push(4'b1101, 7'h46, 6);
      push(4'b1011, 7'h03, 6);
      push(4'b0111, 7'h08, 6);
      goto(11);
      sif.wr = 1'b0;
      chk("mid_pend", 32'(sif.pend), 1);
      goto(31);
      chk("pre_bnd_pend", 32'(sif.pend), 1);
      chk("pre_bnd_frame", 32'(sif.frame), 0);
      goto(32);
      chk("f2_frame", 32'(sif.frame), 1);
      chk("f2_pend", 32'(sif.pend), 0);

      goto(63);
      chk("byp_pre_pend", 32'(sif.pend), 0);
      sif.wr = 1'b1;
      sif.wr_data = 16'h5678;
      push(4'b1110, 7'h00, 6);
      push(4'b1101, 7'h78, 6);
      push(4'b1011, 7'h02, 6);
      push(4'b0111, 7'h12, 6);
      goto(64);
      sif.wr = 1'b0;
      chk("byp_frame", 32'(sif.frame), 1);
      chk("byp_pend", 32'(sif.pend), 0);
      goto(65);
      chk("byp_pend2", 32'(sif.pend), 0);

      goto(95);
      sif.blank_mask = 4'b0101;
      mask_on = 1;
      push(4'b1101, 7'h78, 6);
      push(4'b0111, 7'h12, 6);
      goto(127);
      sif.blank_mask = 4'b0000;
      mask_on = 0;
      push(4'b1110, 7'h00, 6);
      push(4'b1101, 7'h78, 6);
      push(4'b1011, 7'h02, 3);

      goto(148);
      sif.en = 1'b0;
      goto(149);
      chk("en_off_an", 32'(sif.an), 32'hF);
      chk("en_off_seg", 32'(sif.seg), 32'h7F);
      goto(152);
      sif.en = 1'b1;
      push(4'b1110, 7'h00, 6);
      t = -1;
      goto(0);
      chk("reen_frame", 32'(sif.frame), 1);

      goto(7);
      sif.wr = 1'b1;
      sif.wr_data = 16'h9999;
      goto(8);
      chk("pre_rst_pend", 32'(sif.pend), 1);
      reset = 1'b1;
      sif.wr_data = 16'hFFFF;
      goto(9);
      reset = 1'b0;
      sif.wr = 1'b0;
      chk("rst2_pend", 32'(sif.pend), 0);
      chk("rst2_an", 32'(sif.an), 32'hF);
      chk("rst2_seg", 32'(sif.seg), 32'h7F);
      chk("rst2_frame", 32'(sif.frame), 0);
      for (int i = 0; i < 4; i++)
         push(~(4'b0001 << i), 7'h40, 6);
      goto(10);
      chk("rst2_f_frame", 32'(sif.frame), 1);
      chk("rst2_f_pend", 32'(sif.pend), 0);
      goto(44);

      chk("one_digit", 32'(multi), 0);
      chk("mask_an", 32'(mviol), 0);
      chk("dark_seg", 32'(darkbad), 0);
      chk("seg_stable", 32'(segbad), 0);
      chk("sb_left", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles per digit slot; legal range GUARD+1 <= DIV <= 65535.
REQ-002 SHALL have parameter GUARD, default 4: blanked cycles at the start of each slot (anti-ghosting); legal range 1..DIV-1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  scan enable; 0 turns the display off.
REQ-006 SHALL have port wr  input  1  one-cycle strobe that loads wr_data into the shadow register.
REQ-007 SHALL have port wr_data  input  16  four hex nibbles; nibble k = bits [4k+3:4k] drives digit k.
REQ-008 SHALL have port blank_mask  input  4  bit k=1 keeps digit k dark; sampled live.
REQ-009 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-010 SHALL have port an  output  4  active-low digit enables, registered; at most one bit low.
REQ-011 SHALL have port pend  output  1  high while the shadow holds data not yet shown.
REQ-012 SHALL have port frame  output  1  one-cycle pulse on every frame boundary.

Function
REQ-013 SHALL implement states IDLE, GUARD and DRIVE, with a prescaler cnt (0..DIV-1) and a digit index dig (0..3).
REQ-014 SHALL, in IDLE, drive an=4'hF, seg=7'h7F, cnt=0 and dig=0; en=1 moves to GUARD on the next edge.
REQ-015 SHALL, in GUARD, drive an=4'hF and seg=7'h7F; at cnt==GUARD-1 it moves to DRIVE, and cnt keeps counting.
REQ-016 SHALL, in DRIVE, drive an[dig]=0 and seg=decode(disp nibble dig); if blank_mask[dig]=1, it drives an=4'hF and seg=7'h7F.
REQ-017 SHALL, at cnt==DIV-1 in DRIVE, set cnt=0, set dig=(dig+1) mod 4 (wrapping 3->0) and move to GUARD.
REQ-018 SHALL use this decode for 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit, active-low).
REQ-019 SHALL define a frame boundary as either the DRIVE->GUARD edge from dig=3 or the IDLE->GUARD edge.
REQ-020 SHALL, on a frame boundary, copy shadow->disp and clear pend if pend=1, and assert frame for that one cycle.
REQ-021 SHALL, on wr=1, load shadow<=wr_data and set pend=1 on the next edge; back-to-back wr overwrites the shadow (last write wins).
REQ-022 SHALL, when wr coincides with a frame boundary, load wr_data straight into disp and leave pend=0 (bypass).
REQ-023 SHALL never change disp mid-frame: all four digits of one frame come from the same disp value.
REQ-024 SHALL, when en=0 in any state, enter IDLE on the next edge; disp, shadow and pend are kept.
REQ-025 SHALL give a frame period of exactly 4*DIV cycles, and each lit digit SHALL be on for DIV-GUARD cycles per frame.
REQ-026 SHALL register seg and an so that both change on the same edge as the state/cnt/dig update they reflect.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, set state=IDLE, cnt=0, dig=0, disp=0, shadow=0, pend=0, frame=0, an=4'hF and seg=7'h7F.
REQ-028 SHALL give reset priority over en and wr; a wr in the reset cycle is dropped.
REQ-029 SHALL, when reset is asserted mid-slot, leave all digits dark on the following cycle.

Verification
REQ-030 Bench SHALL use DIV=8 and GUARD=2 unless stated otherwise.
REQ-031 Scenario: reset, en=1, wr_data=16'h1234 written before en -> frame pulse on the first GUARD cycle; an sequence 1110,1101,1011,0111, each low 6 cycles with a 2-cycle dark gap; seg 19,30,24,79.
REQ-032 Scenario: wr 16'hABCD while digit 1 is lit -> pend=1 next cycle; digits 2 and 3 still show the old value; at the boundary pend=0 and digit 0 shows seg=7'h21.
REQ-033 Scenario: wr on the exact boundary cycle -> new value shown in the same frame, pend never asserts.
REQ-034 Scenario: blank_mask=4'b0101 -> an never has bit 0 or bit 2 low; those slots keep seg=7'h7F for all 8 cycles.
REQ-035 Scenario: en dropped mid-DRIVE on dig=2 -> an=4'hF next cycle; on re-enable, dig=0 and frame pulses.
REQ-036 Scenario: reset asserted together with wr while pend=1 -> pend=0, disp=0; the next enabled frame shows seg=7'h40 on all digits.
